uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between `N_REQ` byte-stream requesters, for example the ALU result path and status/debug sources. It grants the transmitter to one requester at a time and keeps the grant for a whole packet, closed by the `last` flag. It latches each byte, drives the TX start strobe, and follows the TX active/done handshake. It sits between the requesting controllers and the UART TX.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// A grant is held for a whole packet (closed by i_last) and revoked if the owner stalls too long.
module uart_tx_arbiter #(
  parameter int DATA_SIZE    = 8,
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_last,
  input  logic [N_REQ*DATA_SIZE-1:0] i_data,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [DATA_SIZE-1:0]       o_tx_data,
  output logic [N_REQ-1:0]           o_ack,
  output logic [N_REQ-1:0]           o_grant,
  output logic                       o_busy,
  output logic                       o_abort
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, HOLD} state_e;

  state_e                 state_q;
  idx_t                   ptr_q, win_q;
  logic                   last_q;
  logic [CW-1:0]          hold_cnt_q;
  logic                   tx_start_q, busy_q, abort_q;
  logic [DATA_SIZE-1:0]   tx_data_q;
  logic [N_REQ-1:0]       ack_q, grant_q;

  logic [DATA_SIZE-1:0]   lane [N_REQ];
  logic                   sel_any, latch_en;
  idx_t                   sel_idx, latch_idx;

  function automatic logic [N_REQ-1:0] onehot(input idx_t idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic idx_t next_idx(input idx_t idx);
    return (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = i_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // Scan downwards so the requester closest to ptr_q is written last and wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int   j;
      idx_t k;
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      k = IW'(j);
      if (i_req[k]) begin
        sel_any = 1'b1;
        sel_idx = k;
      end
    end
  end

  always_comb begin
    latch_en  = 1'b0;
    latch_idx = win_q;
    case (state_q)
      IDLE: begin
        latch_en  = sel_any;
        latch_idx = sel_idx;
      end
      WAIT_DONE: latch_en = i_tx_done && !last_q && i_req[win_q];
      HOLD:      latch_en = i_req[win_q];
      default:   latch_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    if (!i_reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      ack_q   <= '0;
      abort_q <= 1'b0;
      if (latch_en) begin
        win_q      <= latch_idx;
        grant_q    <= onehot(latch_idx);
        tx_data_q  <= lane[latch_idx];
        last_q     <= i_last[latch_idx];
        ack_q      <= onehot(latch_idx);
        tx_start_q <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= START;
      end else begin
        case (state_q)
          START: begin
            if (i_tx_active) begin
              tx_start_q <= 1'b0;
              state_q    <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (i_tx_done) begin
              if (last_q) begin
                grant_q <= '0;
                busy_q  <= 1'b0;
                ptr_q   <= next_idx(win_q);
                state_q <= IDLE;
              end else begin
                hold_cnt_q <= '0;
                state_q    <= HOLD;
              end
            end
          end
          HOLD: begin
            // Counter stops at its terminal value, so it can never wrap.
            if (hold_cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
              abort_q <= 1'b1;
              grant_q <= '0;
              busy_q  <= 1'b0;
              ptr_q   <= next_idx(win_q);
              state_q <= IDLE;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_abort    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-lane byte sources, a UART TX model,
// and expected (lane, byte) pairs checked against every ack.
module tb_uart_tx_arbiter;

  localparam int DW     = 8;
  localparam int NR     = 4;
  localparam int HT     = 16;
  localparam int TX_LEN = 10;

  typedef struct packed {logic last; logic [DW-1:0] data;} src_t;
  typedef struct packed {logic [1:0] idx; logic [DW-1:0] data;} exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req, last;
  logic [NR*DW-1:0] data;
  logic             tx_active, tx_done;
  logic             tx_start, busy, abort_p;
  logic [DW-1:0]    tx_data;
  logic [NR-1:0]    ack, grant;

  src_t lane_q [NR][$];
  exp_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tx_cnt  = 0;
  int   ack_cnt [NR];

  uart_tx_arbiter #(.DATA_SIZE(DW), .N_REQ(NR), .HOLD_TIMEOUT(HT)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_last(last), .i_data(data),
    .i_tx_active(tx_active), .i_tx_done(tx_done), .o_tx_start(tx_start),
    .o_tx_data(tx_data), .o_ack(ack), .o_grant(grant), .o_busy(busy), .o_abort(abort_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input logic [1:0] i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic send(input int ln, input logic [DW-1:0] d, input logic lst, input bit expect_ack);
    lane_q[ln].push_back('{last: lst, data: d});
    if (expect_ack) exp_q.push_back('{idx: 2'(ln), data: d});
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      if (lane_q[k].size() > 0) begin
        req[k]             = 1'b1;
        last[k]            = lane_q[k][0].last;
        data[k*DW +: DW]   = lane_q[k][0].data;
      end else begin
        req[k]  = 1'b0;
        last[k] = 1'b0;
      end
    end
  endtask

  // One clock: sample just after the edge, score acks, then update sources and TX model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("ack_lane", 64'(ack), 64'(oh(e.idx)));
        check("ack_grant", 64'(grant), 64'(oh(e.idx)));
        check("ack_data", 64'(tx_data), 64'(e.data));
        check("ack_start", 64'(tx_start), 64'(1));
      end
    end
    for (int k = 0; k < NR; k++) begin
      if (ack[k]) begin
        ack_cnt[k]++;
        if (lane_q[k].size() > 0) void'(lane_q[k].pop_front());
      end
    end
    drive_inputs();
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
      end
    end else if (tx_start && !tx_active) begin
      tx_active = 1'b1;
      tx_cnt    = TX_LEN;
    end
  endtask

  // Run until every expected ack is seen and the arbiter is idle; count grant glitches.
  task automatic drain(input string tag, input logic [NR-1:0] hold_grant, output int bad);
    int n;
    n   = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (hold_grant != '0 && busy && grant !== hold_grant) bad++;
    end while ((exp_q.size() != 0 || busy) && n < 2000);
    check($sformatf("%s_drained", tag), 64'({exp_q.size() == 0, busy}), 64'(2'b10));
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] g, input bit need_wait_done);
    int n;
    n = 0;
    while (!(grant == g && (!need_wait_done || !tx_start)) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(grant), 64'(g));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_done && n < 200);
    check(tag, 64'(tx_done), 64'(1));
  endtask

  initial begin
    int bad, base, dn, early;
    rst_n     = 1'b0;
    req       = '0;
    last      = '0;
    data      = '0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    for (int k = 0; k < NR; k++) ack_cnt[k] = 0;

    // Reset with all four requesting; the first grant afterwards must go to lane 0.
    for (int k = 0; k < NR; k++) send(k, 8'(8'h10 + k * 8'h11), 1'b1, 1'b1);
    drive_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_outputs", 64'({tx_start, tx_data, ack, grant, busy, abort_p}), 64'(0));
    end
    rst_n = 1'b1;
    drain("rst_order", '0, bad);

    // Single two-byte packet from lane 2.
    base = ack_cnt[2];
    send(2, 8'hA5, 1'b0, 1'b1);
    send(2, 8'h3C, 1'b1, 1'b1);
    drain("single_pkt", 4'b0100, bad);
    check("single_grant_held", 64'(bad), 64'(0));
    check("single_ack_count", 64'(ack_cnt[2] - base), 64'(2));
    check("single_grant_clear", 64'(grant), 64'(0));

    // Round robin from a fresh pointer: lanes 0, 1, 3 with single-byte packets.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      send(0, 8'(8'h40 + r), 1'b1, 1'b1);
      send(1, 8'(8'h50 + r), 1'b1, 1'b1);
      send(3, 8'(8'h70 + r), 1'b1, 1'b1);
    end
    drain("round_robin", '0, bad);

    // Packet lock: lane 1 sends three bytes while lane 0 waits.
    base = ack_cnt[0];
    send(1, 8'hB1, 1'b0, 1'b1);
    send(1, 8'hB2, 1'b0, 1'b1);
    send(1, 8'hB3, 1'b1, 1'b1);
    wait_grant("lock_grant1", 4'b0010, 1'b0);
    send(0, 8'hC0, 1'b1, 1'b1);
    dn = 0;
    for (int n = 0; n < 200 && dn < 3; n++) begin
      tick();
      if (tx_done) dn++;
    end
    check("lock_done_count", 64'(dn), 64'(3));
    check("lock_no_ack0", 64'(ack_cnt[0] - base), 64'(0));
    tick();
    check("lock_release", 64'(grant), 64'(0));
    tick();
    check("lock_next_grant", 64'(grant), 64'(4'b0001));
    drain("lock", '0, bad);

    // Stall: lane 3 sends a non-last byte then goes quiet; lane 0 waits behind it.
    send(3, 8'h5A, 1'b0, 1'b1);
    wait_grant("stall_grant3", 4'b1000, 1'b0);
    send(0, 8'h66, 1'b1, 1'b1);
    wait_done("stall_done");
    early = 0;
    for (int c = 0; c < HT; c++) begin
      tick();
      if (abort_p || grant != 4'b1000) early++;
    end
    check("stall_hold_clean", 64'(early), 64'(0));
    tick();
    check("stall_abort", 64'({abort_p, grant, busy}), 64'({1'b1, 4'b0000, 1'b0}));
    tick();
    check("stall_abort_pulse", 64'(abort_p), 64'(0));
    check("stall_next_grant", 64'(grant), 64'(4'b0001));
    drain("stall", '0, bad);

    // Reset in WAIT_DONE; the model's later done must not produce an ack.
    send(2, 8'h11, 1'b0, 1'b1);
    send(2, 8'h22, 1'b1, 1'b0);
    wait_grant("midrst_wait", 4'b0100, 1'b1);
    base = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    rst_n = 1'b0;
    lane_q[2].delete();
    tick();
    check("midrst_outputs", 64'({tx_start, tx_data, ack, grant, busy, abort_p}), 64'(0));
    rst_n = 1'b1;
    wait_done("midrst_done");
    for (int c = 0; c < 3; c++) tick();
    check("midrst_no_ack", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - base), 64'(0));
    check("midrst_idle", 64'({grant, busy}), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
